rr_burst_scheduler: RTL
=======================

Name: rr_burst_scheduler

Overview:
Round-robin scheduler that shares one burst-oriented datapath (shared bus/memory port) between N requesters. It selects one requester and holds the grant for a whole burst of a declared length, counting accepted beats. It releases on burst completion, requester abort or stall timeout, with a guaranteed one-cycle turnaround gap between owners. It sits between the requester ports and the shared resource's beat handshake.

Parameters:
N, 4, number of requesters (2..8)
LEN_W, 4, width of per-requester burst length field
TIMEOUT, 16, consecutive stalled XFER cycles before forced release (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  per-requester request level; held high for the whole burst
burst_len  input  N*LEN_W  requester i length in bits [i*LEN_W +: LEN_W]; beats = value+1
beat_valid  input  1  resource accepted one beat of the current owner this cycle
grant  output  N  one-hot registered grant, all-zero when idle
grant_id  output  $clog2(N)  index of current owner, 0 when idle
busy  output  1  high while in XFER
beats_left  output  LEN_W  remaining beats minus one for the current burst
done  output  1  one-cycle pulse: burst completed normally
abort  output  1  one-cycle pulse: owner dropped req before last beat
timeout_err  output  1  one-cycle pulse: forced release after TIMEOUT stalled cycles

Behaviour:
- Reset (clk with rst=1): state IDLE, grant=0, grant_id=0, busy=0, beats_left=0, done=abort=timeout_err=0, rr pointer ptr=0, stall counter=0. rst has priority over every other event, including mid-burst; grant drops at that edge.
- States: IDLE, XFER.
- IDLE: if req!=0 at an edge, winner = first i with req[i]=1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - At that edge: grant=onehot(winner), grant_id=winner, beats_left=burst_len[winner], stall=0, state XFER.
  - Latency: req high in cycle t gives grant in cycle t+1.
  - If req==0: remain IDLE, outputs idle.
- XFER (busy=1). Evaluated at each edge, priority top-down:
  1. req[grant_id]==0: release, abort pulse next cycle. No beat counted, even if beat_valid=1 in that cycle.
  2. beat_valid=1 and beats_left==0: release, done pulse.
  3. beat_valid=1: beats_left-=1, stall=0.
  4. beat_valid=0: stall+=1. When stall reaches TIMEOUT-1 and beat_valid=0: release, timeout_err pulse.
- Release: grant=0, grant_id=0, busy=0, beats_left=0, state IDLE, ptr=(owner+1) mod N (wraps N-1 to 0). Applies identically for done, abort and timeout.
- Turnaround: after any release, at least one full cycle with grant=0 before the next grant. Arbitration occurs at the edge ending that IDLE cycle.
- Pulses are registered, high for exactly one cycle (the cycle after the releasing edge) and mutually exclusive.
- The burst_len of the winner is sampled only at grant. Later changes to burst_len are ignored.
- Changes on req of non-owners during XFER are ignored.
- beat_valid in IDLE is ignored.
- A length of 0 means 1 beat. Maximum is 2^LEN_W beats (16 with default).
- Fairness: with all N requesting continuously, each requester is granted exactly once per N bursts.

Test Plan:
- Single requester: req=4'b0100, len[2]=3, beat_valid=1 continuously → grant=0100 from t+1 for 4 cycles, done pulse, grant=0 for 1 cycle, regrant; ptr=3.
- Rotation: req=4'b1111, all len=0, beat_valid=1 → grant sequence 0001,0010,0100,1000,0001, each separated by one idle cycle; grant_id 0,1,2,3,0.
- Wrap/skip: ptr=3 after grant to 2, req=4'b0011 → grant 0001 (skip 3, wrap to 0), then 0010.
- Abort: owner 1, len=7, drop req after 2 beats → abort pulse, no done, next grant goes to requester 2 if it is requesting.
- Timeout: owner 0, len=2, beat_valid=0 for 16 cycles → timeout_err pulse, grant released, beats_left=0; beat_valid pulsing every 15 cycles never times out.
- Reset mid-burst: rst during XFER with beats_left=5 → next cycle grant=0, busy=0, no pulses, ptr=0; then req=4'b1010 → grant 0010.

Source files
------------

// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler
//   Round-robin owner selection for a shared, burst-oriented datapath.
//   A requester wins the bus and keeps it for a whole burst of declared
//   length. Accepted beats are counted down while it owns the bus. Ownership
//   ends on burst completion, when the owner drops req, or after TIMEOUT
//   consecutive stalled cycles. Every release is followed by at least one
//   idle cycle before the next owner is granted.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req          [N] per-requester request level
//   burst_len    [N*LEN_W] requester i length in [i*LEN_W +: LEN_W], beats = value+1
//   beat_valid   resource accepted one beat of the current owner
//   grant        [N] one-hot registered grant, zero when idle
//   grant_id     index of the current owner, zero when idle
//   busy         high while a burst is in progress
//   beats_left   remaining beats minus one
//   done         one-cycle pulse, burst completed
//   abort        one-cycle pulse, owner dropped req early
//   timeout_err  one-cycle pulse, forced release after stall timeout
module rr_burst_scheduler #(
  parameter int N       = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*LEN_W-1:0]     burst_len,
  input  logic                   beat_valid,
  output logic [N-1:0]           grant,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy,
  output logic [LEN_W-1:0]       beats_left,
  output logic                   done,
  output logic                   abort,
  output logic                   timeout_err
);

  localparam int ID_W = $clog2(N);
  localparam int ST_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]   left_q, left_d;
  logic [ST_W-1:0]    stall_q, stall_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic               tmo_q, tmo_d;

  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [ID_W-1:0]    nxt_ptr;
  logic               rel;
  logic [LEN_W-1:0]   len_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_len
    assign len_arr[g] = burst_len[g*LEN_W +: LEN_W];
  end

  // Search ptr, ptr+1, ... wrapping modulo N; first requester found wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
      cand = sum[ID_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign nxt_ptr = (id_q == ID_W'(N-1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    tmo_d   = 1'b0;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d         = XFER;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          id_d            = win_id;
          left_d          = len_arr[win_id];
          stall_d         = '0;
        end
      end
      XFER: begin
        // Owner withdrawal outranks a beat arriving in the same cycle.
        if (!req[id_q]) begin
          rel     = 1'b1;
          abort_d = 1'b1;
        end else if (beat_valid && left_q == '0) begin
          rel    = 1'b1;
          done_d = 1'b1;
        end else if (beat_valid) begin
          left_d  = left_q - 1'b1;
          stall_d = '0;
        end else if (stall_q == ST_W'(TIMEOUT-1)) begin
          rel   = 1'b1;
          tmo_d = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Returning to IDLE guarantees the idle turnaround cycle.
    if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      id_d    = '0;
      left_d  = '0;
      stall_d = '0;
      ptr_d   = nxt_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      left_q  <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign busy        = (state_q == XFER);
  assign beats_left  = left_q;
  assign done        = done_q;
  assign abort       = abort_q;
  assign timeout_err = tmo_q;

endmodule
